// File: rtl/fdvit_pe_pkg.sv
// Shared constants and FSM state type for the patch fetch and embedding projection stages.
package fdvit_pe_pkg;

    localparam int unsigned PE_BIT_WIDTH  = 8;
    localparam int unsigned PE_PIXEL      = 224;
    localparam int unsigned PE_PATCH_SIZE = 16;
    localparam int unsigned PE_CHANNELS   = 3;

    localparam int unsigned NPD = PE_PIXEL / PE_PATCH_SIZE;
    localparam int unsigned NP  = NPD * NPD;
    localparam int unsigned PB  = PE_PATCH_SIZE * PE_PATCH_SIZE * PE_CHANNELS * PE_BIT_WIDTH;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        CAPT  = 3'd2,
        VALID = 3'd3,
        DONE  = 3'd4
    } pe_state_e;

endpackage

// File: rtl/patch_addr_gen.sv
// Raster walk over patch origins: column steps by PATCH_SIZE, wrapping into the next patch row.
module patch_addr_gen #(
    parameter  int unsigned PIXEL      = 224,
    parameter  int unsigned PATCH_SIZE = 16,
    localparam int unsigned PW         = $clog2(PIXEL),
    localparam int unsigned NPD_L      = PIXEL / PATCH_SIZE,
    localparam int unsigned NP_L       = NPD_L * NPD_L,
    localparam int unsigned IDX_W      = $clog2(NP_L)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             clear,
    output logic [PW-1:0]    blk_row,
    output logic [PW-1:0]    blk_col,
    output logic [IDX_W-1:0] patch_idx,
    output logic             is_last
);

    // One extra bit so a column step landing exactly on PIXEL is visible.
    logic [PW:0] col_sum_c;
    logic [PW:0] row_sum_c;

    assign col_sum_c = {1'b0, blk_col} + (PW+1)'(PATCH_SIZE);
    assign row_sum_c = {1'b0, blk_row} + (PW+1)'(PATCH_SIZE);
    assign is_last   = (patch_idx == IDX_W'(NP_L - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            blk_row   <= '0;
            blk_col   <= '0;
            patch_idx <= '0;
        end else if (advance) begin
            patch_idx <= patch_idx + IDX_W'(1);
            if (col_sum_c == (PW+1)'(PIXEL)) begin
                blk_col <= '0;
                if (row_sum_c < (PW+1)'(PIXEL)) begin
                    blk_row <= PW'(row_sum_c);
                end
            end else begin
                blk_col <= PW'(col_sum_c);
            end
        end
    end

endmodule

// File: rtl/patch_fetch_ctrl.sv
// Walks the image in patch order, reads each patch from the image SRAM and hands it downstream.
module patch_fetch_ctrl
    import fdvit_pe_pkg::*;
#(
    parameter  int unsigned BIT_WIDTH  = PE_BIT_WIDTH,
    parameter  int unsigned PIXEL      = PE_PIXEL,
    parameter  int unsigned PATCH_SIZE = PE_PATCH_SIZE,
    parameter  int unsigned CHANNELS   = PE_CHANNELS,
    localparam int unsigned PW         = $clog2(PIXEL),
    localparam int unsigned NPD_L      = PIXEL / PATCH_SIZE,
    localparam int unsigned NP_L       = NPD_L * NPD_L,
    localparam int unsigned PB_L       = PATCH_SIZE * PATCH_SIZE * CHANNELS * BIT_WIDTH,
    localparam int unsigned IDX_W      = $clog2(NP_L)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sram_w_en,
    output logic [PW-1:0]    blk_row,
    output logic [PW-1:0]    blk_col,
    input  logic [PB_L-1:0]  sram_data,
    output logic             patch_valid,
    input  logic             patch_ready,
    output logic [PB_L-1:0]  patch_data,
    output logic [IDX_W-1:0] patch_idx,
    output logic             patch_last,
    output logic             busy,
    output logic             done
);

    pe_state_e state;
    logic      advance_c;
    logic      clear_c;
    logic      is_last;

    // Step to the next patch on every accepted non-final patch; zero the walk on start and on completion.
    assign advance_c = (state == VALID) && patch_ready && !patch_last;
    assign clear_c   = ((state == IDLE) && start) || (state == DONE);

    patch_addr_gen #(
        .PIXEL      (PIXEL),
        .PATCH_SIZE (PATCH_SIZE)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .advance   (advance_c),
        .clear     (clear_c),
        .blk_row   (blk_row),
        .blk_col   (blk_col),
        .patch_idx (patch_idx),
        .is_last   (is_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            patch_valid <= 1'b0;
            patch_last  <= 1'b0;
            patch_data  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                    end
                end
                // SRAM skips the read while it is being written, so hold the address and retry.
                ISSUE: begin
                    if (!sram_w_en) begin
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    patch_data  <= sram_data;
                    patch_valid <= 1'b1;
                    patch_last  <= is_last;
                    state       <= VALID;
                end
                VALID: begin
                    if (patch_ready) begin
                        patch_valid <= 1'b0;
                        patch_last  <= 1'b0;
                        if (patch_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_patch_fetch_ctrl.sv
// Directed bench for patch_fetch_ctrl with a behavioural image SRAM.
module tb_patch_fetch_ctrl;

    localparam int unsigned PB    = 6144;
    localparam int unsigned PW    = 8;
    localparam int unsigned IDX_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             sram_w_en;
    logic [PW-1:0]    blk_row;
    logic [PW-1:0]    blk_col;
    logic [PB-1:0]    sram_data;
    logic             patch_valid;
    logic             patch_ready;
    logic [PB-1:0]    patch_data;
    logic [IDX_W-1:0] patch_idx;
    logic             patch_last;
    logic             busy;
    logic             done;

    int n_vec = 0;
    int n_err = 0;
    int xfers = 0;
    int x5    = 0;
    int x0;
    int w;

    patch_fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .sram_w_en   (sram_w_en),
        .blk_row     (blk_row),
        .blk_col     (blk_col),
        .sram_data   (sram_data),
        .patch_valid (patch_valid),
        .patch_ready (patch_ready),
        .patch_data  (patch_data),
        .patch_idx   (patch_idx),
        .patch_last  (patch_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // pixel(r,c,ch) = (r + c + 64*ch) mod 256; R plane, then G, then B, each row-major.
    function automatic logic [PB-1:0] gen_patch(input int r0, input int c0);
        logic [PB-1:0] v;
        v = '0;
        for (int ch = 0; ch < 3; ch++)
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++)
                    v[((ch*256) + (i*16) + j)*8 +: 8] = 8'((r0 + i + c0 + j + ch*64) % 256);
        return v;
    endfunction

    // Synchronous-read SRAM: data appears the cycle after a non-write cycle.
    always @(posedge clk) begin
        if (!sram_w_en) sram_data <= gen_patch(int'(blk_row), int'(blk_col));
    end

    always @(posedge clk) begin
        if (!reset && patch_valid && patch_ready) begin
            xfers++;
            if (patch_idx == 8'd5) x5++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sram_w_en = 1'b0; patch_ready = 1'b0;
        tick; tick;
        chk("rst_valid", 64'(patch_valid), 64'd0);
        chk("rst_last",  64'(patch_last),  64'd0);
        chk("rst_busy",  64'(busy),        64'd0);
        chk("rst_done",  64'(done),        64'd0);
        chk("rst_row",   64'(blk_row),     64'd0);
        chk("rst_col",   64'(blk_col),     64'd0);
        chk("rst_idx",   64'(patch_idx),   64'd0);
        chk("rst_data",  64'(patch_data === '0), 64'd1);

        reset = 1'b0; patch_ready = 1'b1;
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("lat_busy1",  64'(busy),        64'd1);
        chk("lat_valid1", 64'(patch_valid), 64'd0);
        tick;
        chk("lat_valid2", 64'(patch_valid), 64'd0);
        tick;
        chk("lat_valid3", 64'(patch_valid), 64'd1);

        x0 = xfers;
        for (int k = 0; k < 196; k++) begin
            w = 0;
            while (!patch_valid && w < 20) begin
                tick;
                w++;
            end
            chk("valid_wait", 64'(patch_valid), 64'd1);
            chk("idx",  64'(patch_idx),  64'(k));
            chk("last", 64'(patch_last), 64'(k == 195));
            chk("row",  64'(blk_row),    64'((k / 14) * 16));
            chk("col",  64'(blk_col),    64'((k % 14) * 16));
            chk("data", 64'(patch_data === gen_patch((k / 14) * 16, (k % 14) * 16)), 64'd1);
            if (k == 15) begin
                chk("p15_r0", 64'(patch_data[7:0]),    64'd32);
                chk("p15_g0", 64'(patch_data[2055:2048]), 64'd96);
                chk("p15_b0", 64'(patch_data[4103:4096]), 64'd160);
            end
            if (k == 5) begin
                patch_ready = 1'b0;
                for (int h = 0; h < 10; h++) begin
                    tick;
                    chk("hold_valid", 64'(patch_valid), 64'd1);
                    chk("hold_idx",   64'(patch_idx),   64'd5);
                    chk("hold_data",  64'(patch_data === gen_patch(0, 80)), 64'd1);
                end
                patch_ready = 1'b1;
            end
            if (k == 50) start = 1'b1;
            tick;
            start = 1'b0;
            chk("post_hs_valid", 64'(patch_valid), 64'd0);
            if (k == 12) begin
                sram_w_en = 1'b1;
                for (int h = 0; h < 4; h++) begin
                    tick;
                    chk("wen_valid", 64'(patch_valid), 64'd0);
                    chk("wen_busy",  64'(busy),        64'd1);
                    chk("wen_row",   64'(blk_row),     64'd0);
                    chk("wen_col",   64'(blk_col),     64'd208);
                end
                sram_w_en = 1'b0;
            end
        end
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy",  64'(busy), 64'd1);
        tick;
        chk("done_clr",  64'(done),      64'd0);
        chk("idle_busy", 64'(busy),      64'd0);
        chk("idle_idx",  64'(patch_idx), 64'd0);
        chk("idle_row",  64'(blk_row),   64'd0);
        chk("idle_col",  64'(blk_col),   64'd0);
        chk("xfer_total", 64'(xfers - x0), 64'd196);
        chk("xfer_idx5",  64'(x5),         64'd1);

        start = 1'b1;
        tick;
        start = 1'b0;
        w = 0;
        while (!(patch_valid && patch_idx == 8'd100) && w < 400) begin
            tick;
            w++;
        end
        chk("reach_idx100", 64'(patch_valid && patch_idx == 8'd100), 64'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("mid_rst_valid", 64'(patch_valid), 64'd0);
        chk("mid_rst_last",  64'(patch_last),  64'd0);
        chk("mid_rst_busy",  64'(busy),        64'd0);
        chk("mid_rst_done",  64'(done),        64'd0);
        chk("mid_rst_row",   64'(blk_row),     64'd0);
        chk("mid_rst_col",   64'(blk_col),     64'd0);
        chk("mid_rst_idx",   64'(patch_idx),   64'd0);
        chk("mid_rst_data",  64'(patch_data === '0), 64'd1);

        start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        chk("restart_valid", 64'(patch_valid), 64'd1);
        chk("restart_idx",   64'(patch_idx),   64'd0);
        chk("restart_row",   64'(blk_row),     64'd0);
        chk("restart_col",   64'(blk_col),     64'd0);
        chk("restart_data",  64'(patch_data === gen_patch(0, 0)), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/patch_fetch_ctrl.md
PATCH_FETCH_CTRL -- requirements
Module: patch_fetch_ctrl

Interface
REQ-001 Parameter BIT_WIDTH, 8, bits per pixel.
REQ-002 Parameter PIXEL, 224, image height/width in pixels.
REQ-003 Parameter PATCH_SIZE, 16, patch edge in pixels; PIXEL SHALL be a multiple of PATCH_SIZE.
REQ-004 Parameter CHANNELS, 3, colour planes (R, G, B).
REQ-005 Derived: PW=$clog2(PIXEL); NPD=PIXEL/PATCH_SIZE (14); NP=NPD*NPD (196); PB=PATCH_SIZE*PATCH_SIZE*CHANNELS*BIT_WIDTH (6144).
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 start  in  1  begin a full-image patch scan; sampled only in IDLE.
REQ-009 sram_w_en  in  1  image-SRAM write enable; SRAM performs no read in a cycle where it is high.
REQ-010 blk_row  out  PW  top-left row of requested patch, to SRAM block_row.
REQ-011 blk_col  out  PW  top-left column of requested patch, to SRAM block_col.
REQ-012 sram_data  in  PB  flattened patch from SRAM (R plane, then G, then B; row-major); valid one cycle after a read cycle.
REQ-013 patch_valid  out  1  patch_data/patch_idx/patch_last valid.
REQ-014 patch_ready  in  1  downstream accepts.
REQ-015 patch_data  out  PB  captured patch, same layout as sram_data.
REQ-016 patch_idx  out  $clog2(NP)  raster index = (blk_row/PATCH_SIZE)*NPD + blk_col/PATCH_SIZE.
REQ-017 patch_last  out  1  high with patch_idx==NP-1.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse after last patch handshake.

Function
REQ-020 FSM states IDLE, ISSUE, CAPT, VALID, DONE; all outputs registered.
REQ-021 IDLE: start=1 -> ISSUE with blk_row=0, blk_col=0, patch_idx=0; start ignored in any other state.
REQ-022 ISSUE: blk_row/blk_col held; sram_w_en=0 -> CAPT; sram_w_en=1 -> remain in ISSUE (read retried).
REQ-023 CAPT: patch_data <= sram_data at end of cycle, -> VALID; blk_row/blk_col unchanged through CAPT.
REQ-024 VALID: patch_valid=1; patch_data, patch_idx, patch_last stable until patch_valid&&patch_ready.
REQ-025 Handshake with patch_last=0: blk_col += PATCH_SIZE; if new blk_col==PIXEL then blk_col=0, blk_row += PATCH_SIZE; patch_idx += 1; -> ISSUE.
REQ-026 Handshake with patch_last=1: -> DONE; DONE asserts done=1 one cycle, -> IDLE, blk_row/blk_col/patch_idx cleared.
REQ-027 Latency: start at cycle N -> patch_valid at N+3 with sram_w_en=0; steady throughput one patch per 3 cycles with patch_ready held high.
REQ-028 patch_ready high outside VALID has no effect; patch_valid never asserted outside VALID.
REQ-029 Address arithmetic in PW+1 bits to detect wrap; blk_row never exceeds PIXEL-PATCH_SIZE.

Reset
REQ-030 reset, incl. mid-scan, SHALL force IDLE next cycle; patch_valid, patch_last, busy, done, blk_row, blk_col, patch_idx = 0; patch_data = all zeros.
REQ-031 reset has priority over start, sram_w_en, patch_ready.

Structure
REQ-032 Package fdvit_pe_pkg SHALL hold PB, NP, NPD constants and the state enum, shared with the embedding projection stage.
REQ-033 Row/column/index counters SHALL live in one sub-module patch_addr_gen (advance, clear inputs; blk_row, blk_col, patch_idx, is_last outputs); FSM and patch register in top.

Verification
REQ-034 Reset, start pulse, ready=1 -> 196 patches, idx 0..195 in order, done one cycle after idx 195 accepted; cycle 0 start -> first patch_valid cycle 3.
REQ-035 SRAM model with pixel(r,c,ch)=(r+c+ch*64) mod 256 -> patch idx 15 has blk_row=16, blk_col=16, R byte0=32, G byte0=96, B byte0=160.
REQ-036 patch_ready=0 for 10 cycles on idx 5 -> patch_valid, patch_data, patch_idx held constant; exactly one transfer for idx 5.
REQ-037 sram_w_en=1 for 4 cycles during ISSUE of idx 13 -> FSM stays ISSUE, then captures correct patch (blk_row=0, blk_col=208); idx 14 wraps to blk_row=16, blk_col=0.
REQ-038 reset asserted during VALID of idx 100 -> next cycle all outputs 0, busy=0; new start restarts at idx 0.
REQ-039 start pulsed while busy -> ignored, sequence and patch count unchanged.
